// File: rtl/vdot_operand_loader.sv
// Operand loader for the 16-lane vector dot-product stage: assembles A/B vectors beat by beat,
// launches the stage, captures the result. Optional `VDOT_LOAD_LAST_EN adds the in_last early-end port.
module vdot_operand_loader #(
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_a,
    input  logic [15:0]  in_b,
`ifdef VDOT_LOAD_LAST_EN
    input  logic         in_last,
`endif
    output logic [255:0] dot_a,
    output logic [255:0] dot_b,
    output logic         dot_start,
    input  logic         dot_done,
    input  logic [15:0]  dot_out,
    input  logic         dot_v,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [15:0]  res_data,
    output logic         res_v,
    output logic         res_err
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t         state_r;
    logic [4:0]     cnt_r;
    logic [7:0]     tmo_r;
    logic [255:0]   a_r;
    logic [255:0]   b_r;
    logic           in_ready_r;
    logic           dot_start_r;
    logic           res_valid_r;
    logic [15:0]    res_data_r;
    logic           res_v_r;
    logic           res_err_r;
    logic           accept_s;
    logic           last_s;

    // Beat acceptance and end-of-fill detection
    always_comb begin
        accept_s = in_valid & in_ready_r & (state_r == FILL);
`ifdef VDOT_LOAD_LAST_EN
        last_s   = (cnt_r == 5'd15) | in_last;
`else
        last_s   = (cnt_r == 5'd15);
`endif
    end

    // Control FSM with registered handshake outputs and lane/result storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            cnt_r       <= 5'd0;
            tmo_r       <= 8'd0;
            a_r         <= 256'd0;
            b_r         <= 256'd0;
            in_ready_r  <= 1'b1;
            dot_start_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= 16'd0;
            res_v_r     <= 1'b0;
            res_err_r   <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        a_r[{cnt_r[3:0], 4'b0000} +: 16] <= in_a;
                        b_r[{cnt_r[3:0], 4'b0000} +: 16] <= in_b;
                        cnt_r <= cnt_r + 5'd1;
                        if (last_s) begin
                            state_r     <= LAUNCH;
                            in_ready_r  <= 1'b0;
                            dot_start_r <= 1'b1;
                        end else begin
                            state_r     <= FILL;
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                LAUNCH: begin
                    tmo_r <= tmo_r + 8'd1;
                    // A done in the final allowed cycle still beats the abort
                    if (dot_done) begin
                        state_r     <= HOLD;
                        dot_start_r <= 1'b0;
                        res_valid_r <= 1'b1;
                        res_data_r  <= dot_out;
                        res_v_r     <= dot_v;
                        res_err_r   <= 1'b0;
                    end else if ((tmo_r + 8'd1) == TMO_LIMIT) begin
                        state_r     <= HOLD;
                        dot_start_r <= 1'b0;
                        res_valid_r <= 1'b1;
                        res_data_r  <= 16'd0;
                        res_v_r     <= 1'b0;
                        res_err_r   <= 1'b1;
                    end else begin
                        state_r <= LAUNCH;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state_r     <= FILL;
                        cnt_r       <= 5'd0;
                        tmo_r       <= 8'd0;
                        a_r         <= 256'd0;
                        b_r         <= 256'd0;
                        res_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r     <= FILL;
                    cnt_r       <= 5'd0;
                    tmo_r       <= 8'd0;
                    a_r         <= 256'd0;
                    b_r         <= 256'd0;
                    in_ready_r  <= 1'b1;
                    dot_start_r <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign dot_a     = a_r;
    assign dot_b     = b_r;
    assign dot_start = dot_start_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_v     = res_v_r;
    assign res_err   = res_err_r;

endmodule

// File: tb/tb_vdot_operand_loader.sv
// Self-checking bench for vdot_operand_loader: scoreboard of expected results per operation.
module tb_vdot_operand_loader;

    localparam int TMO = 4;
    localparam int BUDGET = 50;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_a;
    logic [15:0]  in_b;
    logic         in_last;
    logic [255:0] dot_a;
    logic [255:0] dot_b;
    logic         dot_start;
    logic         dot_done;
    logic [15:0]  dot_out;
    logic         dot_v;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_data;
    logic         res_v;
    logic         res_err;
    logic         tie;
    logic         done_manual;

    int total = 0;
    int bad = 0;

    logic [15:0] va [16];
    logic [15:0] vb [16];
    logic [17:0] exp_q [$];

    assign dot_done = tie ? dot_start : done_manual;

    always #5 clk = ~clk;

    vdot_operand_loader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
`ifdef VDOT_LOAD_LAST_EN
        .in_last(in_last),
`endif
        .dot_a(dot_a), .dot_b(dot_b), .dot_start(dot_start), .dot_done(dot_done),
        .dot_out(dot_out), .dot_v(dot_v), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_v(res_v), .res_err(res_err)
    );

    function automatic logic [255:0] pack_a(input int n);
        logic [255:0] r = 256'd0;
        for (int i = 0; i < n; i++) r[i*16 +: 16] = va[i];
        return r;
    endfunction

    function automatic logic [255:0] pack_b(input int n);
        logic [255:0] r = 256'd0;
        for (int i = 0; i < n; i++) r[i*16 +: 16] = vb[i];
        return r;
    endfunction

    task automatic randomize_vec();
        for (int i = 0; i < 16; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
        end
    endtask

    // starts at a negedge in FILL, ends at the negedge after the last beat's posedge
    task automatic feed(input int n, input logic lst);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_a = va[i];
            in_b = vb[i];
            in_last = lst && (i == n - 1);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL feed_ready beat %0d: got %b want 1", i, in_ready);
            end
            @(negedge clk);
        end
        in_last = 1'b0;
    endtask

    task automatic wait_rv(output int cyc);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, dot_start, res_valid, res_v, res_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 10000", {in_ready, dot_start, res_valid, res_v, res_err});
        end
        total++;
        if (res_data !== 16'd0 || dot_a !== 256'd0 || dot_b !== 256'd0) begin
            bad++;
            $display("FAIL reset_data: res_data=%h dot_a=%h want 0", res_data, dot_a);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (dot_a !== 256'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: dot_a=%h in_ready=%b want 0/1", dot_a, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [17:0] e;
        tie = 1'b1; dot_out = 16'h0088; dot_v = 1'b0; res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            va[i] = 16'(i + 1);
            vb[i] = 16'd1;
        end
        exp_q.push_back({1'b0, 1'b0, 16'h0088});
        feed(16, 1'b0);
        in_valid = 1'b0;
        total++;
        if ({dot_start, res_valid, in_ready} !== 3'b100) begin
            bad++;
            $display("FAIL basic_launch: start/valid/ready got %b want 100", {dot_start, res_valid, in_ready});
        end
        total++;
        if (dot_a[15:0] !== 16'd1 || dot_a[255:240] !== 16'd16) begin
            bad++;
            $display("FAIL basic_lanes: lane0=%h lane15=%h want 1/10", dot_a[15:0], dot_a[255:240]);
        end
        total++;
        if (dot_a !== pack_a(16) || dot_b !== pack_b(16)) begin
            bad++;
            $display("FAIL basic_vec: dot_a=%h want %h", dot_a, pack_a(16));
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || dot_start !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency: res_valid=%b dot_start=%b want 1/0", res_valid, dot_start);
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({res_err, res_v, res_data} !== e) begin
                bad++;
                $display("FAIL basic_result: got %h want %h", {res_err, res_v, res_data}, e);
            end
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || dot_a !== 256'd0) begin
            bad++;
            $display("FAIL basic_return: res_valid=%b in_ready=%b dot_a=%h", res_valid, in_ready, dot_a);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        logic [17:0] e;
        tie = 1'b1; dot_v = 1'b1; dot_out = 16'h7C00; res_ready = 1'b1;
        randomize_vec();
        exp_q.push_back({1'b0, 1'b1, 16'h7C00});
        feed(16, 1'b0);
        in_valid = 1'b0;
        wait_rv(cyc);
        total++;
        if (cyc >= BUDGET) begin
            bad++;
            $display("FAIL overflow_wait: no res_valid within %0d cycles", BUDGET);
        end else begin
            e = exp_q.pop_front();
            if ({res_err, res_v, res_data} !== e) begin
                bad++;
                $display("FAIL overflow_result: got %h want %h", {res_err, res_v, res_data}, e);
            end
        end
        dot_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [17:0] e;
        logic [15:0] a0, b0;
        tie = 1'b1; done_manual = 1'b0; dot_v = 1'b0; dot_out = 16'h3C5A; res_ready = 1'b0;
        randomize_vec();
        a0 = 16'($urandom); b0 = 16'($urandom);
        exp_q.push_back({1'b0, 1'b0, 16'h3C5A});
        feed(16, 1'b0);
        in_a = a0; in_b = b0; in_valid = 1'b1;
        wait_rv(cyc);
        total++;
        if (cyc >= BUDGET) begin
            bad++;
            $display("FAIL bp_wait: no res_valid within %0d cycles", BUDGET);
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== exp_q[0][15:0]) begin
                bad++;
                $display("FAIL bp_hold cyc %0d: in_ready=%b res_valid=%b res_data=%h want 0/1/%h",
                         k, in_ready, res_valid, res_data, exp_q[0][15:0]);
            end
            if (k == 3) begin
                tie = 1'b0; done_manual = 1'b1; dot_out = 16'hDEAD;
            end
            if (k == 6) begin
                tie = 1'b1; done_manual = 1'b0;
            end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        total++;
        if ({res_err, res_v, res_data} !== e) begin
            bad++;
            $display("FAIL bp_result: got %h want %h", {res_err, res_v, res_data}, e);
        end
        res_ready = 1'b1;
        dot_out = 16'h1111;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b res_valid=%b want 1/0", in_ready, res_valid);
        end
        randomize_vec();
        va[0] = a0; vb[0] = b0;
        exp_q.push_back({1'b0, 1'b0, 16'h1111});
        feed(16, 1'b0);
        in_valid = 1'b0;
        total++;
        if (dot_a !== pack_a(16) || dot_b !== pack_b(16)) begin
            bad++;
            $display("FAIL bp_next_vec: dot_a=%h want %h", dot_a, pack_a(16));
        end
        wait_rv(cyc);
        total++;
        if (cyc >= BUDGET) begin
            bad++;
            $display("FAIL bp_next_wait: no res_valid within %0d cycles", BUDGET);
        end else begin
            e = exp_q.pop_front();
            if ({res_err, res_v, res_data} !== e) begin
                bad++;
                $display("FAIL bp_next_result: got %h want %h", {res_err, res_v, res_data}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        logic [17:0] e;
        tie = 1'b0; done_manual = 1'b1; dot_out = 16'h1234; dot_v = 1'b1; res_ready = 1'b1;
        randomize_vec();
        exp_q.push_back({1'b1, 1'b0, 16'h0000});
        feed(16, 1'b0);
        in_valid = 1'b0;
        done_manual = 1'b0;
        n = 0;
        while (dot_start === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != TMO) begin
            bad++;
            $display("FAIL timeout_len: dot_start cycles got %0d want %0d", n, TMO);
        end
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL timeout_valid: res_valid got %b want 1", res_valid);
        end else begin
            e = exp_q.pop_front();
            if ({res_err, res_v, res_data} !== e) begin
                bad++;
                $display("FAIL timeout_result: got %h want %h", {res_err, res_v, res_data}, e);
            end
        end
        dot_v = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_done_at_limit();
        logic [17:0] e;
        tie = 1'b0; done_manual = 1'b0; dot_out = 16'h0BEE; dot_v = 1'b0; res_ready = 1'b1;
        randomize_vec();
        exp_q.push_back({1'b0, 1'b0, 16'h0BEE});
        feed(16, 1'b0);
        in_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        total++;
        if (dot_start !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL limit_launch: dot_start=%b res_valid=%b want 1/0", dot_start, res_valid);
        end
        done_manual = 1'b1;
        @(negedge clk);
        done_manual = 1'b0;
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL limit_valid: res_valid got %b want 1", res_valid);
        end else begin
            e = exp_q.pop_front();
            if ({res_err, res_v, res_data} !== e) begin
                bad++;
                $display("FAIL limit_result: got %h want %h", {res_err, res_v, res_data}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_midreset();
        int cyc;
        logic [17:0] e;
        tie = 1'b1; dot_out = 16'h4321; dot_v = 1'b0; res_ready = 1'b1;
        randomize_vec();
        feed(9, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || dot_start !== 1'b0 || dot_a !== 256'd0) begin
            bad++;
            $display("FAIL midrst_clear: in_ready=%b res_valid=%b dot_a=%h", in_ready, res_valid, dot_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        randomize_vec();
        exp_q.push_back({1'b0, 1'b0, 16'h4321});
        feed(16, 1'b0);
        in_valid = 1'b0;
        total++;
        if (dot_a !== pack_a(16) || dot_b !== pack_b(16)) begin
            bad++;
            $display("FAIL midrst_vec: dot_a=%h want %h", dot_a, pack_a(16));
        end
        wait_rv(cyc);
        total++;
        if (cyc >= BUDGET || exp_q.size() != 1) begin
            bad++;
            $display("FAIL midrst_wait: cycles=%0d pending=%0d want <%0d/1", cyc, exp_q.size(), BUDGET);
        end else begin
            e = exp_q.pop_front();
            if ({res_err, res_v, res_data} !== e) begin
                bad++;
                $display("FAIL midrst_result: got %h want %h", {res_err, res_v, res_data}, e);
            end
        end
        @(negedge clk);
    endtask

`ifdef VDOT_LOAD_LAST_EN
    task automatic test_last();
        int cyc;
        logic [17:0] e;
        tie = 1'b1; dot_out = 16'h0777; dot_v = 1'b0; res_ready = 1'b1;
        randomize_vec();
        exp_q.push_back({1'b0, 1'b0, 16'h0777});
        feed(3, 1'b1);
        in_valid = 1'b0;
        total++;
        if (dot_start !== 1'b1 || dot_a[255:48] !== 208'd0 || dot_b[255:48] !== 208'd0) begin
            bad++;
            $display("FAIL last_launch: dot_start=%b dot_a=%h", dot_start, dot_a);
        end
        total++;
        if (dot_a !== pack_a(3) || dot_b !== pack_b(3)) begin
            bad++;
            $display("FAIL last_vec: dot_a=%h want %h", dot_a, pack_a(3));
        end
        wait_rv(cyc);
        total++;
        if (cyc >= BUDGET) begin
            bad++;
            $display("FAIL last_wait: no res_valid within %0d cycles", BUDGET);
        end else begin
            e = exp_q.pop_front();
            if ({res_err, res_v, res_data} !== e) begin
                bad++;
                $display("FAIL last_result: got %h want %h", {res_err, res_v, res_data}, e);
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; in_last = 1'b0;
        dot_out = 16'd0; dot_v = 1'b0; res_ready = 1'b1; tie = 1'b1; done_manual = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_timeout();
        test_done_at_limit();
        test_midreset();
`ifdef VDOT_LOAD_LAST_EN
        test_last();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
